// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and the ALU:
// FSM state codes, opcode/funct fields, ALUOp codes and ALUControl codes.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;

    // Controller state encoding; codes 12-15 are illegal.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    // ALUOp: 00 add, 01 sub, 1x decode funct
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes, shared with the ALU
    localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_controller_alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field to the 3-bit ALUControl.
// Ports:
//   i_alu_op        ALUOp from the controller FSM
//   i_funct         instruction funct field
//   o_alu_control_c combinational ALUControl
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [ALUOP_W-1:0]  i_alu_op,
    input  logic [FUNCT_W-1:0]  i_funct,
    output logic [ALUCTL_W-1:0] o_alu_control_c
);

    // ALUOp 1x defers to funct; unknown funct falls back to add.
    always_comb begin
        o_alu_control_c = ALUCTL_ADD;
        if (i_alu_op[1]) begin
            case (i_funct)
                FUNCT_ADD: o_alu_control_c = ALUCTL_ADD;
                FUNCT_SUB: o_alu_control_c = ALUCTL_SUB;
                FUNCT_AND: o_alu_control_c = ALUCTL_AND;
                FUNCT_OR:  o_alu_control_c = ALUCTL_OR;
                FUNCT_SLT: o_alu_control_c = ALUCTL_SLT;
                default:   o_alu_control_c = ALUCTL_ADD;
            endcase
        end else if (i_alu_op[0]) begin
            o_alu_control_c = ALUCTL_SUB;
        end
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving all datapath enables and mux selects.
// Ports:
//   clk, reset       rising-edge clock, async active-high reset (-> FETCH)
//   op, funct        instruction opcode and funct fields
//   Zero_Flag        ALU zero output, used only in BRANCH
//   ALUControl       ALU operation
//   ALUSrcA/ALUSrcB  ALU operand selects
//   PCSrc, IorD      next-PC and memory address selects
//   RegDst, MemtoReg register write address/data selects
//   IRWrite, MemWrite, RegWrite, PCEn  write enables (0 while reset)
//   state            current FSM state
module mips_mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                Zero_Flag,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic                IorD,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                PCEn,
    output logic [STATE_W-1:0]  state
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ALUOP_W-1:0]  w_alu_op;
    logic                w_pc_write;
    logic                w_branch;
    logic                w_ir_write;
    logic                w_mem_write;
    logic                w_reg_write;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; illegal codes recover to FETCH
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next_state = S_MEMWB;
            S_EXECUTE: w_next_state = S_ALUWB;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Moore output decode
    always_comb begin
        w_alu_op    = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                IorD        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA  = 1'b1;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_alu_op = ALUOP_SUB;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            S_JUMP: begin
                PCSrc      = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op        (w_alu_op),
        .i_funct         (funct),
        .o_alu_control_c (ALUControl)
    );

    // Enables are gated by reset so an aborted instruction writes nothing
    assign IRWrite  = w_ir_write  & ~reset;
    assign MemWrite = w_mem_write & ~reset;
    assign RegWrite = w_reg_write & ~reset;
    assign PCEn     = (w_pc_write | (w_branch & Zero_Flag)) & ~reset;
    assign state    = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: the driver issues whole
// instructions and queues the expected per-cycle outputs derived from the
// instruction's step list; a monitor compares on every falling edge.
module tb_mips_mc_controller;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] aluc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       irw;
        logic       memw;
        logic       regw;
        logic       pcen;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       Zero_Flag = 1'b0;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, PCEn;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    obs_t exp_q[$];

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .Zero_Flag(Zero_Flag),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .PCEn(PCEn), .state(state)
    );

    always #5 clk = ~clk;

    // R-type ALU operation by funct
    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for one instruction step
    function automatic obs_t step_outputs(input int st, input logic [5:0] fn, input logic z);
        obs_t e;
        e = '0;
        e.st   = 4'(st);
        e.aluc = 3'b010;
        case (st)
            0:  begin e.srcb = 2'b01; e.irw = 1'b1; e.pcen = 1'b1; end
            1:  e.srcb = 2'b11;
            2, 9: begin e.srca = 1'b1; e.srcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.memtoreg = 1'b1; e.regw = 1'b1; end
            5:  begin e.iord = 1'b1; e.memw = 1'b1; end
            6:  begin e.srca = 1'b1; e.aluc = rtype_alu(fn); end
            7:  begin e.regdst = 1'b1; e.regw = 1'b1; end
            8:  begin e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            10: e.regw = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Outputs expected while reset is held: FETCH selects, no enables
    function automatic obs_t reset_outputs();
        obs_t e;
        e = step_outputs(0, 6'd0, 1'b0);
        e.irw  = 1'b0;
        e.pcen = 1'b0;
        return e;
    endfunction

    // Step list for an opcode
    function automatic void steps_for(input logic [5:0] o, output int seq[6], output int n);
        seq = '{0, 1, 0, 0, 0, 0};
        case (o)
            6'b100011: begin seq[2] = 2; seq[3] = 3; seq[4] = 4; n = 5; end
            6'b101011: begin seq[2] = 2; seq[3] = 5; n = 4; end
            6'b000000: begin seq[2] = 6; seq[3] = 7; n = 4; end
            6'b001000: begin seq[2] = 9; seq[3] = 10; n = 4; end
            6'b000100: begin seq[2] = 8; n = 3; end
            6'b000010: begin seq[2] = 11; n = 3; end
            default:   n = 2;
        endcase
    endfunction

    function automatic obs_t actual();
        obs_t a;
        a = '{state, ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
              IRWrite, MemWrite, RegWrite, PCEn};
        return a;
    endfunction

    // Monitor: compare every cycle that has a queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = actual();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs state=%0d: got %h expected %h", e.st, a, e);
            end
        end
    end

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            reset = 1'b1;
            exp_q.push_back(reset_outputs());
        end
    endtask

    // zmode: 0 -> Zero_Flag 0, 1 -> 1, otherwise random each cycle
    task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input int zmode,
                             input int stop_after);
        int seq[6];
        int n;
        steps_for(o, seq, n);
        if (stop_after > 0 && stop_after < n) n = stop_after;
        for (int s = 0; s < n; s++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            op    = o;
            funct = fn;
            Zero_Flag = (zmode == 0) ? 1'b0 : (zmode == 1) ? 1'b1 : 1'($urandom);
            exp_q.push_back(step_outputs(seq[s], fn, Zero_Flag));
        end
    endtask

    function automatic logic [5:0] random_op(input int kind);
        logic [5:0] o;
        case (kind)
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: o = 6'b000000;
            3: o = 6'b001000;
            4: o = 6'b000100;
            5: o = 6'b000010;
            default: begin
                o = 6'($urandom);
                while (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                       o == 6'b001000 || o == 6'b000100 || o == 6'b000010)
                    o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    function automatic logic [5:0] random_funct();
        logic [5:0] valid[5];
        valid = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if ($urandom_range(0, 3) != 0) return valid[$urandom_range(0, 4)];
        return 6'($urandom);
    endfunction

    initial begin
        // Reset held two cycles, then lw
        hold_reset(2);
        run_instr(6'b100011, 6'd0, 2, 0);
        // R-type slt, and, or
        run_instr(6'b000000, 6'b101010, 2, 0);
        run_instr(6'b000000, 6'b100100, 2, 0);
        run_instr(6'b000000, 6'b100101, 2, 0);
        // beq taken / not taken
        run_instr(6'b000100, 6'd0, 1, 0);
        run_instr(6'b000100, 6'd0, 0, 0);
        // j, unknown opcode, addi, sw
        run_instr(6'b000010, 6'd0, 2, 0);
        run_instr(6'b111111, 6'd0, 2, 0);
        run_instr(6'b001000, 6'd0, 2, 0);
        run_instr(6'b101011, 6'd0, 2, 0);

        // sw aborted by a mid-cycle reset in MEMWRITE
        run_instr(6'b101011, 6'd0, 2, 4);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 ||
            PCEn !== 1'b0 || IRWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_abort: state=%0d MemWrite=%b RegWrite=%b PCEn=%b IRWrite=%b required state=0 enables=0",
                     state, MemWrite, RegWrite, PCEn, IRWrite);
        end
        hold_reset(1);

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            logic [5:0] o;
            o = random_op($urandom_range(0, 6));
            run_instr(o, (o == 6'b000000) ? random_funct() : 6'($urandom), 2, 0);
        end

        @(negedge clk); #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the lab MIPS processor: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps and drives every datapath enable and mux select. It sits directly upstream of the ALU, generating its 3-bit `ALUControl` through an ALU decoder, and consumes the ALU's `Zero_Flag` to resolve branches. Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

## Interface
- No parameters; all encodings are fixed constants.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces state to FETCH
- `op`  in  6  instruction opcode, bits [31:26] of the instruction register
- `funct`  in  6  function field, bits [5:0] of the instruction register
- `Zero_Flag`  in  1  ALU zero output
- `ALUControl`  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- `ALUSrcA`  out  1  0 = PC, 1 = register A
- `ALUSrcB`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2
- `PCSrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `RegDst`  out  1  0 = rt, 1 = rd
- `MemtoReg`  out  1  0 = ALUOut, 1 = data register
- `IRWrite`, `MemWrite`, `RegWrite`  out  1 each  write enables
- `PCEn`  out  1  PC load enable: PCWrite | (Branch & Zero_Flag)
- `state`  out  4  current state, for debug and bench visibility

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 are illegal and go to FETCH on the next edge.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (lw/sw), EXECUTE (R-type), BRANCH (beq), ADDIEX (addi), JUMP (j), or FETCH for any other opcode (treated as a nop).
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB and JUMP all → FETCH.
- Per-state outputs. Any signal not listed is 0; ALUOp is an internal 2-bit code.
  - FETCH: ALUSrcB=01, ALUOp=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMREAD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIWB: RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- ALU decode:
  - ALUOp 00 → 010 (add).
  - ALUOp 01 → 110 (sub).
  - ALUOp 1x decodes funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other funct → 010.

## Timing
- Outputs are combinational from `state`, except `PCEn`, which also depends on `Zero_Flag` in the same cycle.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- While `reset` is high:
  - `state` = 0 (FETCH).
  - `IRWrite`, `MemWrite`, `RegWrite` and `PCEn` are forced to 0.
  - Selects take their FETCH values, and `ALUControl` = 010.
- First FETCH write enables assert in the cycle after reset deasserts.
- Reset mid-instruction aborts it immediately, with no further write enables. The instruction is not resumed.
- `Zero_Flag` is ignored in every state except BRANCH.

## Structure
- Package `mips_ctrl_pkg` holds the state encoding, opcode and funct constants, ALUOp codes and ALUControl codes. The future ALU rework shares the same ALUControl constants.
- Sub-module `alu_decoder` (ALUOp and funct in, ALUControl out) is purely combinational.
- Top level contains the state register, next-state logic, output decode and the `PCEn` gate.

## Test plan
- Reset held 2 cycles, then released → `state` 0, all enables 0 during reset; IRWrite=1 and PCEn=1 in the first free cycle; `state` 1 next cycle.
- lw (op 100011) → `state` sequence 0,1,2,3,4,0; ALUControl=010 in MEMADR; IorD=1 in MEMREAD; RegWrite=1 with MemtoReg=1 in MEMWB only.
- R-type slt (op 000000, funct 101010) → EXECUTE gives ALUControl=111 and ALUSrcA=1; ALUWB gives RegDst=1 and RegWrite=1. Repeat for funct 100100 → 000 and 100101 → 001.
- beq in BRANCH with Zero_Flag=1 → PCEn=1, ALUControl=110, PCSrc=01; with Zero_Flag=0 → PCEn=0; next state FETCH in both cases.
- j (op 000010) → sequence 0,1,11,0 with PCSrc=10 and PCEn=1 in JUMP. Unknown op 111111 → DECODE goes straight back to FETCH with no writes.
- Reset asserted mid-clock in MEMWRITE → `state` 0 immediately, MemWrite drops to 0 asynchronously, no store completes.
